// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 4;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

  typedef struct packed {
    logic load;
    logic cnt_reset;
    logic decrement;
    logic add;
    logic shift;
    logic busy;
    logic done;
  } mult_ctrl_t;

  // Moore output decode: strobes are a pure function of the state.
  function automatic mult_ctrl_t decode_ctrl(input mult_state_t s);
    mult_ctrl_t c;
    c = '0;
    case (s)
      LOAD: begin
        c.load      = 1'b1;
        c.cnt_reset = 1'b1;
        c.busy      = 1'b1;
      end
      TEST: c.busy = 1'b1;
      ADD: begin
        c.add  = 1'b1;
        c.busy = 1'b1;
      end
      SHIFT: begin
        c.shift     = 1'b1;
        c.decrement = 1'b1;
        c.busy      = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_controller.sv
// Sequencing FSM for the shift-add multiplier: load, WIDTH test/add/shift
// iterations driven by the external down-counter, then a done/ack handshake.
module mult_controller
  import mult_pkg::mult_state_t, mult_pkg::mult_ctrl_t, mult_pkg::decode_ctrl,
         mult_pkg::MULT_WIDTH;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic             q0,
  input  logic [CNT_W-1:0] count,
  output logic             LOAD,
  output logic             RESET,
  output logic             DECREMENT,
  output logic             ADD,
  output logic             SHIFT,
  output logic             busy,
  output logic             done
);

  mult_state_t state_q;
  mult_state_t state_next;
  mult_ctrl_t  ctrl_q;

  // State names collide with the strobe ports, so they are package-qualified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= mult_pkg::IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_next;
      ctrl_q  <= decode_ctrl(state_next);
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      mult_pkg::IDLE:  if (start) state_next = mult_pkg::LOAD;
      mult_pkg::LOAD:  state_next = mult_pkg::TEST;
      mult_pkg::TEST:  state_next = q0 ? mult_pkg::ADD : mult_pkg::SHIFT;
      mult_pkg::ADD:   state_next = mult_pkg::SHIFT;
      // count is the pre-decrement value; <=1 also catches a zeroed counter
      mult_pkg::SHIFT: state_next = (count <= CNT_W'(1)) ? mult_pkg::DONE
                                                         : mult_pkg::TEST;
      mult_pkg::DONE:  if (ack) state_next = mult_pkg::IDLE;
      default:         state_next = mult_pkg::IDLE;
    endcase
    if (abort && (state_q inside {mult_pkg::LOAD, mult_pkg::TEST,
                                  mult_pkg::ADD, mult_pkg::SHIFT})) begin
      state_next = mult_pkg::IDLE;
    end
  end

  assign LOAD      = ctrl_q.load;
  assign RESET     = ctrl_q.cnt_reset;
  assign DECREMENT = ctrl_q.decrement;
  assign ADD       = ctrl_q.add;
  assign SHIFT     = ctrl_q.shift;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller with a behavioural counter and
// multiplier shift register standing in for the datapath.
module tb_mult_controller;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ack   = 1'b0;
  logic          q0;
  logic [CW-1:0] count;
  logic          ld, rcnt, dec, add_s, shf, busy, done;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  // datapath stand-in
  logic [W-1:0]  mult_operand = '0;
  logic [W-1:0]  mreg = '0;
  logic [CW-1:0] cnt = '0;
  logic          cnt_fault = 1'b0;

  always #5 clk = ~clk;

  mult_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .q0(q0), .count(count),
    .LOAD(ld), .RESET(rcnt), .DECREMENT(dec), .ADD(add_s), .SHIFT(shf),
    .busy(busy), .done(done)
  );

  assign outs  = {ld, rcnt, dec, add_s, shf, busy, done};
  assign q0    = mreg[0];
  assign count = cnt_fault ? '0 : cnt;

  always @(posedge clk) begin
    if (ld) mreg <= mult_operand;
    else if (shf) mreg <= mreg >> 1;
    if (rcnt && !dec) cnt <= CW'(W);
    else if (dec && !rcnt && cnt != '0) cnt <= cnt - CW'(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe exclusivity, sampled every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_dec_exclusive", int'(rcnt & dec), 0);
      check("add_shift_exclusive", int'(add_s & shf), 0);
      check("busy_done_exclusive", int'(busy & done), 0);
    end
  end

  typedef struct {
    logic [W-1:0] mult;
    int           hold;
    bit           abort_in_done;
    int           exp_lat;
    int           exp_adds;
  } vec_t;

  // Pulse start; returns at the negedge where LOAD should be showing.
  task automatic launch(input logic [W-1:0] m);
    @(negedge clk);
    mult_operand = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles from the LOAD sample until done, tallying strobes.
  task automatic measure(output int lat, output int adds, output int shifts,
                         output int decs, output int loads,
                         output logic [W-1:0] obs, output bit to);
    int iter;
    bit add_seen;
    lat = 0; adds = 0; shifts = 0; decs = 0; loads = 0;
    obs = '0; iter = 0; add_seen = 1'b0; to = 1'b0;
    while (!done && !to) begin
      if (ld) loads++;
      if (dec) decs++;
      if (add_s) begin adds++; add_seen = 1'b1; end
      if (shf) begin
        shifts++;
        if (iter < int'(W)) obs[iter[1:0]] = add_seen;
        iter++;
        add_seen = 1'b0;
      end
      if (lat >= 40) to = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic ack_pulse(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check(name, int'(outs), 0);
  endtask

  task automatic run_one(input vec_t v);
    int lat, adds, shifts, decs, loads;
    logic [W-1:0] obs;
    bit to;
    launch(v.mult);
    measure(lat, adds, shifts, decs, loads, obs, to);
    check("timeout", int'(to), 0);
    check("latency", lat, v.exp_lat);
    check("add_count", adds, v.exp_adds);
    check("shift_count", shifts, int'(W));
    check("dec_count", decs, int'(W));
    check("load_count", loads, 1);
    check("add_pattern", int'(obs), int'(v.mult));
    for (int i = 0; i < v.hold; i++) begin
      abort = v.abort_in_done;
      start = v.abort_in_done;
      @(negedge clk);
      check("done_held", int'({busy, done}), 1);
    end
    abort = 1'b0;
    start = 1'b0;
    ack_pulse("idle_after_ack");
  endtask

  vec_t vecs[6];

  initial begin
    int lat, adds, shifts, decs, loads, n;
    logic [W-1:0] obs;
    bit to;
    vec_t rv;

    vecs[0] = '{4'b0000, 3, 1'b0,  9, 0};
    vecs[1] = '{4'b1111, 1, 1'b0, 13, 4};
    vecs[2] = '{4'b1010, 2, 1'b1, 11, 2};
    vecs[3] = '{4'b0001, 0, 1'b0, 10, 1};
    vecs[4] = '{4'b1000, 2, 1'b1, 10, 1};
    vecs[5] = '{4'b0110, 1, 1'b0, 11, 2};

    @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'(outs), 0);

    for (int i = 0; i < 6; i++) run_one(vecs[i]);

    // random multipliers against the counting model
    for (int i = 0; i < 12; i++) begin
      rv.mult          = W'($urandom_range(0, 15));
      rv.hold          = int'($urandom_range(0, 3));
      rv.abort_in_done = 1'($urandom_range(0, 1));
      rv.exp_lat       = 1 + 2 * int'(W) + $countones(rv.mult);
      rv.exp_adds      = $countones(rv.mult);
      run_one(rv);
    end

    // asynchronous reset in the middle of an ADD
    launch(4'b1111);
    n = 0;
    while (!add_s && n < 20) begin @(negedge clk); n++; end
    check("reach_add", int'(add_s), 1);
    reset = 1'b1;
    #1;
    check("reset_async_clear", int'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'(outs), 0);

    // abort in the second TEST, then a clean multiply
    launch(4'b0000);
    repeat (3) @(negedge clk);
    check("in_second_test", int'(outs), 7'b0000010);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_to_idle", int'(outs), 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("no_done_after_abort", n, 0);
    rv = '{4'b0000, 0, 1'b0, 9, 0};
    run_one(rv);

    // zeroed counter ends after the first SHIFT
    cnt_fault = 1'b1;
    launch(4'b0000);
    measure(lat, adds, shifts, decs, loads, obs, to);
    check("fault_latency", lat, 3);
    check("fault_shifts", shifts, 1);
    cnt_fault = 1'b0;
    ack_pulse("fault_idle");

    // back-to-back with start held high; ack wins over start in DONE
    @(negedge clk);
    mult_operand = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    measure(lat, adds, shifts, decs, loads, obs, to);
    check("b2b_first_latency", lat, 11);
    mult_operand = 4'b0011;
    ack_pulse("b2b_idle_gap");
    @(negedge clk);
    check("b2b_reload", int'(ld), 1);
    measure(lat, adds, shifts, decs, loads, obs, to);
    check("b2b_second_latency", lat, 11);
    check("b2b_second_pattern", int'(obs), 3);
    start = 1'b0;
    ack_pulse("b2b_final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
